ecc_secded_pipe: RTL and testbench

//   Parametrised, pipelined Hamming SEC-DED codec: one encode channel, one decode/correct channel, both valid/ready.

---
 rtl/ecc_secded_pipe_pkg.sv | 37 +++
 rtl/ecc_secded_syn.sv | 35 +++
 rtl/ecc_secded_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_ecc_secded_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_secded_pipe_pkg.sv
// ecc_pkg: shared sizing helpers, data-bit position map and error classes for the SEC-DED codec.
package ecc_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SBE   = 2'd1,
    DBE   = 2'd2
  } err_class_e;

  // Smallest P with 2^P >= DW+P+1.
  function automatic int ecc_pw(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic int ecc_cw(input int dw);
    return dw + ecc_pw(dw) + 1;
  endfunction

  // 0-based code bit holding data bit idx: data fills the non-power-of-two 1-indexed positions in order.
  function automatic int ecc_data_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 1; pos < 1024; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == idx) res = pos - 1;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ecc_secded_syn.sv
// ecc_secded_syn: combinational Hamming check. ENC=1 ignores parity slots and yields parity bits;
// ENC=0 yields the syndrome of a received word plus its overall parity.
module ecc_secded_syn
  import ecc_pkg::*;
#(
  parameter int DW  = 32,
  parameter bit ENC = 1'b0,
  localparam int PW = ecc_pw(DW),
  localparam int CW = DW + PW + 1
) (
  input  logic [CW-1:0] code_i,
  output logic [PW-1:0] syn_o,
  output logic          op_o
);

  logic [CW-1:0] code_m;

  always_comb begin
    code_m = code_i;
    if (ENC) begin
      for (int k = 0; k < PW; k++) code_m[(1 << k) - 1] = 1'b0;
      code_m[CW-1] = 1'b0;
    end
  end

  // Syndrome is the XOR of the 1-indexed positions of every set bit below the overall parity bit.
  always_comb begin
    syn_o = '0;
    for (int i = 0; i < CW - 1; i++) begin
      if (code_m[i]) syn_o = syn_o ^ PW'(i + 1);
    end
    op_o = ^code_m;
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: pipelined SEC-DED codec, 1-stage encoder and 2-stage decoder with error counters.
// Define ECC_ERR_INJECT_EN to add the one-shot INJ_MASK/INJ_ARM error injection on the encode path.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int PW    = ecc_pw(DW),
  parameter int CW    = DW + PW + 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_VLD,
  output logic             WR_RDY,
  input  logic [DW-1:0]    WR_DATA,
  output logic             ENC_VLD,
  input  logic             ENC_RDY,
  output logic [CW-1:0]    ENC_CODE,
  input  logic             RD_VLD,
  output logic             RD_RDY,
  input  logic [CW-1:0]    RD_CODE,
  output logic             DEC_VLD,
  input  logic             DEC_RDY,
  output logic [DW-1:0]    DEC_DATA,
  output logic             DEC_SBE,
  output logic             DEC_DBE,
  output logic [PW-1:0]    DEC_SYN,
  output logic [CNT_W-1:0] SBE_CNT,
  output logic [CNT_W-1:0] DBE_CNT,
  output logic             DBE_STKY,
  input  logic             CNT_CLR
`ifdef ECC_ERR_INJECT_EN
  ,
  input  logic [CW-1:0]    INJ_MASK,
  input  logic             INJ_ARM
`endif
);

  logic [CW-1:0]    enc_map;
  logic [CW-1:0]    enc_code_d;
  logic [CW-1:0]    enc_code_q;
  logic [CW-1:0]    inj_mask;
  logic [PW-1:0]    enc_par;
  logic             enc_op;
  logic             enc_vld_q;
  logic             enc_load;

  logic [PW-1:0]    rd_syn;
  logic             rd_op;
  logic             rd_load;
  logic             s2_adv;
  logic             s1_vld_q;
  logic [CW-1:0]    s1_code_q;
  logic [PW-1:0]    s1_syn_q;
  logic             s1_op_q;

  err_class_e       dec_class;
  logic [CW-1:0]    flip_mask;
  logic [CW-1:0]    dec_corr;
  logic [DW-1:0]    dec_data_d;
  logic             dec_vld_q;
  logic [DW-1:0]    dec_data_q;
  logic             dec_sbe_q;
  logic             dec_dbe_q;
  logic [PW-1:0]    dec_syn_q;
  logic             dec_hs;
  logic [CNT_W-1:0] sbe_cnt_q;
  logic [CNT_W-1:0] dbe_cnt_q;
  logic             dbe_stky_q;

  for (genvar gi = 0; gi < DW; gi++) begin : g_map
    localparam int POS = ecc_data_pos(gi);
    assign enc_map[POS]   = WR_DATA[gi];
    assign dec_data_d[gi] = dec_corr[POS];
  end

  for (genvar gi = 0; gi < PW; gi++) begin : g_par_slot
    assign enc_map[(1 << gi) - 1] = 1'b0;
  end
  assign enc_map[CW-1] = 1'b0;

  ecc_secded_syn #(.DW(DW), .ENC(1'b1)) u_enc_syn (
    .code_i (enc_map),
    .syn_o  (enc_par),
    .op_o   (enc_op)
  );

  always_comb begin
    enc_code_d = enc_map;
    for (int k = 0; k < PW; k++) enc_code_d[(1 << k) - 1] = enc_par[k];
    enc_code_d[CW-1] = enc_op ^ (^enc_par);
  end

  assign WR_RDY   = !enc_vld_q || ENC_RDY;
  assign enc_load = WR_VLD && WR_RDY;

`ifdef ECC_ERR_INJECT_EN
  logic [CW-1:0] inj_q;

  // A fresh arm takes priority so a same-cycle load cannot wipe the newly armed mask.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inj_q <= '0;
    end else if (INJ_ARM) begin
      inj_q <= INJ_MASK;
    end else if (enc_load) begin
      inj_q <= '0;
    end
  end
  assign inj_mask = inj_q;
`else
  assign inj_mask = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      enc_vld_q  <= 1'b0;
      enc_code_q <= '0;
    end else if (enc_load) begin
      enc_vld_q  <= 1'b1;
      enc_code_q <= enc_code_d ^ inj_mask;
    end else if (ENC_RDY) begin
      enc_vld_q  <= 1'b0;
    end
  end

  ecc_secded_syn #(.DW(DW), .ENC(1'b0)) u_dec_syn (
    .code_i (RD_CODE),
    .syn_o  (rd_syn),
    .op_o   (rd_op)
  );

  assign s2_adv  = !dec_vld_q || DEC_RDY;
  assign RD_RDY  = !s1_vld_q || s2_adv;
  assign rd_load = RD_VLD && RD_RDY;

  // Syndromes beyond the last code position cannot come from a single flip.
  always_comb begin
    dec_class = CLEAN;
    flip_mask = '0;
    if (s1_syn_q == '0) begin
      dec_class = s1_op_q ? SBE : CLEAN;
    end else if (!s1_op_q) begin
      dec_class = DBE;
    end else if (int'(s1_syn_q) <= CW - 1) begin
      dec_class = SBE;
      flip_mask = CW'(1) << (int'(s1_syn_q) - 1);
    end else begin
      dec_class = DBE;
    end
  end
  assign dec_corr = s1_code_q ^ flip_mask;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld_q   <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_op_q    <= 1'b0;
      dec_vld_q  <= 1'b0;
      dec_data_q <= '0;
      dec_sbe_q  <= 1'b0;
      dec_dbe_q  <= 1'b0;
      dec_syn_q  <= '0;
    end else begin
      if (RD_RDY) s1_vld_q <= RD_VLD;
      if (rd_load) begin
        s1_code_q <= RD_CODE;
        s1_syn_q  <= rd_syn;
        s1_op_q   <= rd_op;
      end
      if (s2_adv) dec_vld_q <= s1_vld_q;
      if (s2_adv && s1_vld_q) begin
        dec_data_q <= dec_data_d;
        dec_sbe_q  <= (dec_class == SBE);
        dec_dbe_q  <= (dec_class == DBE);
        dec_syn_q  <= s1_syn_q;
      end
    end
  end

  assign dec_hs = dec_vld_q && DEC_RDY;

  // Counting only on the output handshake keeps stalled words from being counted twice.
  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      sbe_cnt_q  <= '0;
      dbe_cnt_q  <= '0;
      dbe_stky_q <= 1'b0;
    end else if (dec_hs) begin
      if (dec_sbe_q && (sbe_cnt_q != '1)) sbe_cnt_q <= sbe_cnt_q + CNT_W'(1);
      if (dec_dbe_q && (dbe_cnt_q != '1)) dbe_cnt_q <= dbe_cnt_q + CNT_W'(1);
      if (dec_dbe_q) dbe_stky_q <= 1'b1;
    end
  end

  assign ENC_VLD  = enc_vld_q;
  assign ENC_CODE = enc_code_q;
  assign DEC_VLD  = dec_vld_q;
  assign DEC_DATA = dec_data_q;
  assign DEC_SBE  = dec_sbe_q;
  assign DEC_DBE  = dec_dbe_q;
  assign DEC_SYN  = dec_syn_q;
  assign SBE_CNT  = sbe_cnt_q;
  assign DBE_CNT  = dbe_cnt_q;
  assign DBE_STKY = dbe_stky_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Testbench for ecc_secded_pipe: directed table, random traffic against a parity-check model,
// stall, saturation/clear and reset-while-full sequences.
module tb_ecc_secded_pipe;

  localparam int DW    = 32;
  localparam int PW    = 6;
  localparam int CW    = 39;
  localparam int CNT_W = 16;

  typedef struct {
    logic [CW-1:0] code;
    logic [DW-1:0] data;
    logic          sbe;
    logic          dbe;
    logic [PW-1:0] syn;
  } dec_vec_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             WR_VLD, WR_RDY, ENC_VLD, ENC_RDY;
  logic [DW-1:0]    WR_DATA;
  logic [CW-1:0]    ENC_CODE;
  logic             RD_VLD, RD_RDY, DEC_VLD, DEC_RDY;
  logic [CW-1:0]    RD_CODE;
  logic [DW-1:0]    DEC_DATA;
  logic             DEC_SBE, DEC_DBE, DBE_STKY, CNT_CLR;
  logic [PW-1:0]    DEC_SYN;
  logic [CNT_W-1:0] SBE_CNT, DBE_CNT;

  logic             WR_VLD_b, WR_RDY_b, ENC_VLD_b, ENC_RDY_b;
  logic [DW-1:0]    WR_DATA_b;
  logic [CW-1:0]    ENC_CODE_b;
  logic             RD_VLD_b, RD_RDY_b, DEC_VLD_b, DEC_RDY_b;
  logic [CW-1:0]    RD_CODE_b;
  logic [DW-1:0]    DEC_DATA_b;
  logic             DEC_SBE_b, DEC_DBE_b, DBE_STKY_b, CNT_CLR_b;
  logic [PW-1:0]    DEC_SYN_b;
  logic [1:0]       SBE_CNT_b, DBE_CNT_b;

  always #5 CLK = ~CLK;

  ecc_secded_pipe #(.DW(DW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .WR_VLD(WR_VLD), .WR_RDY(WR_RDY), .WR_DATA(WR_DATA),
    .ENC_VLD(ENC_VLD), .ENC_RDY(ENC_RDY), .ENC_CODE(ENC_CODE),
    .RD_VLD(RD_VLD), .RD_RDY(RD_RDY), .RD_CODE(RD_CODE),
    .DEC_VLD(DEC_VLD), .DEC_RDY(DEC_RDY), .DEC_DATA(DEC_DATA),
    .DEC_SBE(DEC_SBE), .DEC_DBE(DEC_DBE), .DEC_SYN(DEC_SYN),
    .SBE_CNT(SBE_CNT), .DBE_CNT(DBE_CNT), .DBE_STKY(DBE_STKY), .CNT_CLR(CNT_CLR)
  );

  ecc_secded_pipe #(.DW(DW), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST(RST),
    .WR_VLD(WR_VLD_b), .WR_RDY(WR_RDY_b), .WR_DATA(WR_DATA_b),
    .ENC_VLD(ENC_VLD_b), .ENC_RDY(ENC_RDY_b), .ENC_CODE(ENC_CODE_b),
    .RD_VLD(RD_VLD_b), .RD_RDY(RD_RDY_b), .RD_CODE(RD_CODE_b),
    .DEC_VLD(DEC_VLD_b), .DEC_RDY(DEC_RDY_b), .DEC_DATA(DEC_DATA_b),
    .DEC_SBE(DEC_SBE_b), .DEC_DBE(DEC_DBE_b), .DEC_SYN(DEC_SYN_b),
    .SBE_CNT(SBE_CNT_b), .DBE_CNT(DBE_CNT_b), .DBE_STKY(DBE_STKY_b), .CNT_CLR(CNT_CLR_b)
  );

  int       checks = 0;
  int       errors = 0;
  int       exp_sbe = 0;
  int       exp_dbe = 0;
  logic     exp_stky = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Textbook Hamming: data into non-power-of-two positions, parity 2^k covers positions with bit k set.
  function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < PW; k++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos < CW; pos++)
        if (((pos >> k) & 1) == 1) p = p ^ c[pos-1];
      c[(1 << k) - 1] = p;
    end
    c[CW-1] = ^c[CW-2:0];
    return c;
  endfunction

  function automatic void m_decode(input logic [CW-1:0] c, output logic [DW-1:0] d,
                                   output logic sbe, output logic dbe, output logic [PW-1:0] syn);
    logic [CW-1:0] cc;
    logic op;
    int s;
    int j;
    syn = '0;
    for (int k = 0; k < PW; k++)
      for (int pos = 1; pos < CW; pos++)
        if (((pos >> k) & 1) == 1) syn[k] = syn[k] ^ c[pos-1];
    s  = int'(syn);
    op = ^c;
    cc = c;
    sbe = 1'b0;
    dbe = 1'b0;
    if (s == 0) sbe = op;
    else if (!op || s > CW - 1) dbe = 1'b1;
    else begin
      cc[s-1] = ~cc[s-1];
      sbe = 1'b1;
    end
    d = '0;
    j = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = cc[pos-1];
        j++;
      end
    end
  endfunction

  task automatic enc_a(input logic [DW-1:0] d, input logic [CW-1:0] exp);
    int n;
    WR_DATA = d;
    WR_VLD  = 1'b1;
    ENC_RDY = 1'b1;
    n = 0;
    while (!WR_RDY && n < 20) begin @(negedge CLK); n++; end
    chk("enc_wr_rdy", 64'(WR_RDY), 64'(1));
    @(negedge CLK);
    WR_VLD = 1'b0;
    chk("enc_vld", 64'(ENC_VLD), 64'(1));
    chk("enc_code", 64'(ENC_CODE), 64'(exp));
    $display("enc data=%h code=%h", d, ENC_CODE);
  endtask

  task automatic dec_a(input logic [CW-1:0] code, input logic [DW-1:0] ed, input logic esbe,
                       input logic edbe, input logic [PW-1:0] esyn);
    int n;
    RD_CODE = code;
    RD_VLD  = 1'b1;
    DEC_RDY = 1'b1;
    n = 0;
    while (!RD_RDY && n < 20) begin @(negedge CLK); n++; end
    chk("dec_rd_rdy", 64'(RD_RDY), 64'(1));
    @(negedge CLK);
    RD_VLD = 1'b0;
    @(negedge CLK);
    chk("dec_vld_lat2", 64'(DEC_VLD), 64'(1));
    chk("dec_data", 64'(DEC_DATA), 64'(ed));
    chk("dec_sbe", 64'(DEC_SBE), 64'(esbe));
    chk("dec_dbe", 64'(DEC_DBE), 64'(edbe));
    chk("dec_syn", 64'(DEC_SYN), 64'(esyn));
    $display("dec code=%h data=%h sbe=%0d dbe=%0d syn=%0d", code, DEC_DATA, DEC_SBE, DEC_DBE, DEC_SYN);
    if (esbe) exp_sbe++;
    if (edbe) begin exp_dbe++; exp_stky = 1'b1; end
    @(negedge CLK);
    chk("dec_vld_drop", 64'(DEC_VLD), 64'(0));
    chk("sbe_cnt", 64'(SBE_CNT), 64'(exp_sbe));
    chk("dbe_cnt", 64'(DBE_CNT), 64'(exp_dbe));
    chk("dbe_stky", 64'(DBE_STKY), 64'(exp_stky));
  endtask

  task automatic dec_b(input logic [CW-1:0] code, input logic clr);
    int n;
    RD_CODE_b = code;
    RD_VLD_b  = 1'b1;
    n = 0;
    while (!RD_RDY_b && n < 20) begin @(negedge CLK); n++; end
    @(negedge CLK);
    RD_VLD_b = 1'b0;
    n = 0;
    while (!DEC_VLD_b && n < 20) begin @(negedge CLK); n++; end
    chk("b_dec_vld", 64'(DEC_VLD_b), 64'(1));
    CNT_CLR_b = clr;
    @(negedge CLK);
    CNT_CLR_b = 1'b0;
    $display("dec_b code=%h sbe=%0d clr=%0d cnt=%0d", code, DEC_SBE_b, clr, SBE_CNT_b);
  endtask

  initial begin
    dec_vec_t      vt[5];
    logic [DW-1:0] d, ed;
    logic [CW-1:0] c;
    logic          es, eb;
    logic [PW-1:0] ey;
    logic [DW-1:0] sd[3];
    logic [CW-1:0] sc[3];
    int            b1, b2, nflip, got, n, exp_b;
    logic          fire_rd;

    vt[0] = '{39'h40_0000_0007, 32'h0000_0001, 1'b0, 1'b0, 6'd0};
    vt[1] = '{39'h40_0000_0003, 32'h0000_0001, 1'b1, 1'b0, 6'd3};
    vt[2] = '{39'h40_0000_0004, 32'h0000_0001, 1'b0, 1'b1, 6'd3};
    vt[3] = '{39'h00_0000_0007, 32'h0000_0001, 1'b1, 1'b0, 6'd0};
    vt[4] = '{39'h40_C000_0000, 32'h0200_0000, 1'b0, 1'b1, 6'd63};

    RST = 1'b1;
    WR_VLD = 1'b0; WR_DATA = '0; ENC_RDY = 1'b1;
    RD_VLD = 1'b0; RD_CODE = '0; DEC_RDY = 1'b1; CNT_CLR = 1'b0;
    WR_VLD_b = 1'b0; WR_DATA_b = '0; ENC_RDY_b = 1'b1;
    RD_VLD_b = 1'b0; RD_CODE_b = '0; DEC_RDY_b = 1'b1; CNT_CLR_b = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_enc_vld", 64'(ENC_VLD), 64'(0));
    chk("rst_enc_code", 64'(ENC_CODE), 64'(0));
    chk("rst_dec_vld", 64'(DEC_VLD), 64'(0));
    chk("rst_sbe_cnt", 64'(SBE_CNT), 64'(0));
    chk("rst_dbe_stky", 64'(DBE_STKY), 64'(0));
    chk("rst_rd_rdy", 64'(RD_RDY), 64'(1));
    RST = 1'b0;
    @(negedge CLK);

    enc_a(32'h0000_0001, 39'h40_0000_0007);
    enc_a(32'h0000_0000, 39'h00_0000_0000);
    enc_a(32'hFFFF_FFFF, m_encode(32'hFFFF_FFFF));

    for (int i = 0; i < 5; i++) dec_a(vt[i].code, vt[i].data, vt[i].sbe, vt[i].dbe, vt[i].syn);

    // Encode backpressure: output held, no new load.
    WR_VLD = 1'b0; ENC_RDY = 1'b1;
    @(negedge CLK);
    d = $urandom;
    ENC_RDY = 1'b0; WR_VLD = 1'b1; WR_DATA = d;
    @(negedge CLK);
    WR_DATA = ~d;
    chk("enc_stall_wr_rdy", 64'(WR_RDY), 64'(0));
    repeat (3) begin
      @(negedge CLK);
      chk("enc_stall_vld", 64'(ENC_VLD), 64'(1));
      chk("enc_stall_code", 64'(ENC_CODE), 64'(m_encode(d)));
    end
    ENC_RDY = 1'b1;
    @(negedge CLK);
    WR_VLD = 1'b0;
    chk("enc_release_code", 64'(ENC_CODE), 64'(m_encode(~d)));
    @(negedge CLK);
    chk("enc_release_vld", 64'(ENC_VLD), 64'(0));

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      c = m_encode(d);
      enc_a(d, c);
      nflip = $urandom_range(0, 2);
      b1 = $urandom_range(0, CW - 1);
      b2 = $urandom_range(0, CW - 2);
      if (b2 >= b1) b2++;
      if (nflip >= 1) c[b1] = ~c[b1];
      if (nflip == 2) c[b2] = ~c[b2];
      m_decode(c, ed, es, eb, ey);
      dec_a(c, ed, es, eb, ey);
    end

    // Decode stall: three single-flip words, output blocked for five clocks.
    for (int i = 0; i < 3; i++) begin
      sd[i] = $urandom;
      sc[i] = m_encode(sd[i]) ^ (39'h1 << $urandom_range(0, CW - 1));
    end
    DEC_RDY = 1'b0; RD_VLD = 1'b1; RD_CODE = sc[0];
    @(negedge CLK);
    RD_CODE = sc[1];
    @(negedge CLK);
    RD_CODE = sc[2];
    chk("stall_rd_rdy", 64'(RD_RDY), 64'(0));
    repeat (5) begin
      @(negedge CLK);
      chk("stall_dec_vld", 64'(DEC_VLD), 64'(1));
      chk("stall_dec_data", 64'(DEC_DATA), 64'(sd[0]));
      chk("stall_rd_rdy_hold", 64'(RD_RDY), 64'(0));
      chk("stall_sbe_cnt", 64'(SBE_CNT), 64'(exp_sbe));
    end
    DEC_RDY = 1'b1;
    got = 0;
    n = 0;
    while (got < 3 && n < 30) begin
      fire_rd = RD_VLD && RD_RDY;
      if (DEC_VLD) begin
        chk("stall_order_data", 64'(DEC_DATA), 64'(sd[got]));
        chk("stall_order_sbe", 64'(DEC_SBE), 64'(1));
        $display("stall out %0d data=%h", got, DEC_DATA);
        got++;
        exp_sbe++;
      end
      @(negedge CLK);
      n++;
      if (fire_rd) RD_VLD = 1'b0;
    end
    chk("stall_count", 64'(got), 64'(3));
    chk("stall_sbe_total", 64'(SBE_CNT), 64'(exp_sbe));

    // Narrow counter saturation and clear-wins on the handshake cycle.
    exp_b = 0;
    for (int i = 0; i < 5; i++) begin
      dec_b(39'h40_0000_0003, 1'b0);
      exp_b = (exp_b < 3) ? exp_b + 1 : 3;
      chk("b_sbe_cnt_sat", 64'(SBE_CNT_b), 64'(exp_b));
    end
    dec_b(39'h40_0000_0003, 1'b1);
    chk("b_sbe_cnt_clr", 64'(SBE_CNT_b), 64'(0));
    dec_b(39'h40_0000_0004, 1'b0);
    chk("b_dbe_cnt", 64'(DBE_CNT_b), 64'(1));
    chk("b_dbe_stky", 64'(DBE_STKY_b), 64'(1));

    // Reset with both channels full.
    ENC_RDY = 1'b0; WR_VLD = 1'b1; WR_DATA = $urandom;
    DEC_RDY = 1'b0; RD_VLD = 1'b1; RD_CODE = 39'h40_0000_0004;
    repeat (3) @(negedge CLK);
    chk("pre_rst_enc_vld", 64'(ENC_VLD), 64'(1));
    chk("pre_rst_dec_vld", 64'(DEC_VLD), 64'(1));
    RST = 1'b1; WR_VLD = 1'b0; RD_VLD = 1'b0;
    @(negedge CLK);
    chk("full_rst_enc_vld", 64'(ENC_VLD), 64'(0));
    chk("full_rst_enc_code", 64'(ENC_CODE), 64'(0));
    chk("full_rst_dec_vld", 64'(DEC_VLD), 64'(0));
    chk("full_rst_dec_dbe", 64'(DEC_DBE), 64'(0));
    chk("full_rst_sbe_cnt", 64'(SBE_CNT), 64'(0));
    chk("full_rst_dbe_cnt", 64'(DBE_CNT), 64'(0));
    chk("full_rst_stky", 64'(DBE_STKY), 64'(0));
    chk("full_rst_b_stky", 64'(DBE_STKY_b), 64'(0));
    RST = 1'b0;
    DEC_RDY = 1'b1;
    ENC_RDY = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_rst_dec_vld", 64'(DEC_VLD), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
